// File: rtl/qlk0rmuldiv_pkg.sv
// qlk0rmuldiv_pkg: shared constants, state encoding and helpers for the MULDIV divider.
// Revision 1.0
`default_nettype none

package qlk0rmuldiv_pkg;

  localparam int DIVW = 32;
  localparam int CNTW = 5;

  localparam logic [DIVW-1:0] DIVZ_QUO  = '1;
  localparam logic [CNTW-1:0] CNT_START = CNTW'(DIVW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [DIVW-1:0] cond_neg(input logic [DIVW-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qlk0rmuldiv1v1_div_step.sv
// qlk0rmuldiv1v1_div_step: one restoring-division iteration (shift, trial subtract, select).
// Revision 1.0
`default_nettype none

module qlk0rmuldiv1v1_div_step
  import qlk0rmuldiv_pkg::*;
(
  input  logic [DIVW-1:0] i_rem,
  input  logic            i_bit,
  input  logic [DIVW-1:0] i_div,
  output logic [DIVW-1:0] o_rem,
  output logic            o_qbit
);

  logic [DIVW-1:0] w_shift;
  logic [DIVW:0]   w_diff;

  assign w_shift = {i_rem[DIVW-2:0], i_bit};
  assign w_diff  = {1'b0, w_shift} - {1'b0, i_div};

  // A set top remainder bit means the shifted value is >= 2^32 and always exceeds the divisor.
  assign o_qbit = i_rem[DIVW-1] | ~w_diff[DIVW];
  assign o_rem  = o_qbit ? w_diff[DIVW-1:0] : w_shift;

endmodule

`default_nettype wire

// File: rtl/qlk0rmuldiv1v1_div.sv
// qlk0rmuldiv1v1_div: sequential 32-bit signed/unsigned restoring divider, one quotient bit per clock.
// Revision 1.0
`default_nettype none

module qlk0rmuldiv1v1_div
  import qlk0rmuldiv_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            DIVST,
  input  logic            DIVSM,
  input  logic [DIVW-1:0] DIVA,
  input  logic [DIVW-1:0] DIVB,
  output logic [DIVW-1:0] DIVQ,
  output logic [DIVW-1:0] DIVR,
  output logic            DIVBUSY,
  output logic            DIVEND,
  output logic            DIVZ
);

  div_state_e      r_state;
  logic [CNTW-1:0] r_cnt;
  logic [DIVW-1:0] r_rem;
  logic [DIVW-1:0] r_quo;
  logic [DIVW-1:0] r_div;
  logic [DIVW-1:0] r_araw;
  logic            r_signed;
  logic            r_sa;
  logic            r_sb;
  logic            r_zero;
  logic [DIVW-1:0] r_q;
  logic [DIVW-1:0] r_r;
  logic            r_busy;
  logic            r_end;
  logic            r_z;

  logic [DIVW-1:0] w_rem;
  logic            w_qbit;

  qlk0rmuldiv1v1_div_step u_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[DIVW-1]),
    .i_div  (r_div),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_araw   <= '0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_zero   <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_busy   <= 1'b0;
      r_end    <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        IDLE: begin
          if (DIVST) begin
            r_signed <= DIVSM;
            r_sa     <= DIVSM & DIVA[DIVW-1];
            r_sb     <= DIVSM & DIVB[DIVW-1];
            r_zero   <= (DIVB == '0);
            r_araw   <= DIVA;
            r_quo    <= cond_neg(DIVA, DIVSM & DIVA[DIVW-1]);
            r_div    <= cond_neg(DIVB, DIVSM & DIVB[DIVW-1]);
            r_rem    <= '0;
            r_cnt    <= CNT_START;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
          r_rem <= w_rem;
          r_quo <= {r_quo[DIVW-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (r_zero) begin
            r_q <= DIVZ_QUO;
            r_r <= r_araw;
          end else begin
            r_q <= cond_neg(r_quo, r_signed & (r_sa ^ r_sb));
            r_r <= cond_neg(r_rem, r_signed & r_sa);
          end
          r_z     <= r_zero;
          r_end   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DIVQ    = r_q;
  assign DIVR    = r_r;
  assign DIVBUSY = r_busy;
  assign DIVEND  = r_end;
  assign DIVZ    = r_z;

endmodule

`default_nettype wire

// File: tb/tb_qlk0rmuldiv1v1_div.sv
// tb_qlk0rmuldiv1v1_div: directed vectors against a cycle-level arithmetic model of the divider.
// Revision 1.0
`default_nettype none

module tb_qlk0rmuldiv1v1_div;

  logic        clk;
  logic        rst;
  logic        divst;
  logic        divsm;
  logic [31:0] diva;
  logic [31:0] divb;
  logic [31:0] divq;
  logic [31:0] divr;
  logic        divbusy;
  logic        divend;
  logic        divz;

  int checks   = 0;
  int failures = 0;

  qlk0rmuldiv1v1_div dut (
    .CLK     (clk),
    .RST     (rst),
    .DIVST   (divst),
    .DIVSM   (divsm),
    .DIVA    (diva),
    .DIVB    (divb),
    .DIVQ    (divq),
    .DIVR    (divr),
    .DIVBUSY (divbusy),
    .DIVEND  (divend),
    .DIVZ    (divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {divz, quotient, remainder}.
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic m);
    longint sa, sb, q, r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (!m) return {1'b0, a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, q[31:0], r[31:0]};
  endfunction

  // Model: a start in idle yields results exactly 33 edges later.
  logic [31:0] m_q, m_r, p_q, p_r;
  logic        m_z, p_z, m_busy, m_end;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0; m_r <= '0; m_z <= 1'b0; m_busy <= 1'b0; m_end <= 1'b0; m_left <= 0;
      p_q <= '0; p_r <= '0; p_z <= 1'b0;
    end else begin
      m_end <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_q <= p_q; m_r <= p_r; m_z <= p_z; m_end <= 1'b1; m_busy <= 1'b0;
        end
      end else if (divst) begin
        {p_z, p_q, p_r} <= ref_div(diva, divb, divsm);
        m_left <= 33;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_q",    divq,           m_q);
    chk("cyc_r",    divr,           m_r);
    chk("cyc_z",    {31'd0, divz},  {31'd0, m_z});
    chk("cyc_busy", {31'd0, divbusy}, {31'd0, m_busy});
    chk("cyc_end",  {31'd0, divend},  {31'd0, m_end});
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic m);
    diva = a; divb = b; divsm = m; divst = 1'b1;
    @(posedge clk);
    #1 divst = 1'b0;
    diva = 32'hDEAD_BEEF; divb = 32'h0000_0001; divsm = ~m;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (divend) break;
      if (n > 60) begin
        checks++; failures++;
        $display("FAIL timeout: no DIVEND within 60 cycles at %0t", $time);
        break;
      end
    end
  endtask

  task automatic check_res(input string name, input logic [31:0] q, input logic [31:0] r, input logic z);
    chk({name, "_q"}, divq, q);
    chk({name, "_r"}, divr, r);
    chk({name, "_z"}, {31'd0, divz}, {31'd0, z});
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b, input logic m,
                         input logic [31:0] q, input logic [31:0] r, input logic z);
    int n;
    start(a, b, m);
    wait_end(n);
    chk({name, "_lat"}, n, 34);
    check_res(name, q, r, z);
  endtask

  int n;
  int ends_seen;

  initial begin
    rst = 1'b1; divst = 1'b0; divsm = 1'b0; diva = '0; divb = '0;
    repeat (3) @(negedge clk);
    check_res("reset", 32'd0, 32'd0, 1'b0);
    chk("reset_busy", {31'd0, divbusy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("u100_7",   32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0);
    run_div("sm100_7",  32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_div("s100_m7",  32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2,         1'b0);
    run_div("smin_m1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0);
    run_div("zero_div", 32'h0000_1234, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    run_div("u9_3",     32'd9,         32'd3,         1'b0, 32'd3,         32'd0,         1'b0);
    run_div("szero",    32'hFFFF_FF9C, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
    run_div("uff_big",  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1,         32'h7FFF_FFFF, 1'b0);

    // Start pulse while busy must be ignored.
    start(32'd1000, 32'd33, 1'b0);
    repeat (10) @(negedge clk);
    diva = 32'd1; divb = 32'd1; divsm = 1'b0; divst = 1'b1;
    @(posedge clk);
    #1 divst = 1'b0;
    wait_end(n);
    check_res("busy_ign", 32'd30, 32'd10, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_ign_idle", {31'd0, divbusy}, 32'd0);

    // Back-to-back: start held in the DIVEND cycle.
    start(32'd77, 32'd10, 1'b0);
    wait_end(n);
    check_res("b2b_first", 32'd7, 32'd7, 1'b0);
    start(32'd9, 32'd3, 1'b0);
    wait_end(n);
    chk("b2b_lat", n, 34);
    check_res("b2b_second", 32'd3, 32'd0, 1'b0);

    // Asynchronous reset mid-division.
    start(32'd12345, 32'd11, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_res("rst_mid", 32'd0, 32'd0, 1'b0);
    chk("rst_mid_busy", {31'd0, divbusy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ends_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (divend) ends_seen++;
    end
    chk("rst_no_end", ends_seen, 0);
    run_div("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qlk0rmuldiv1v1_div.md
# qlk0rmuldiv1v1_div

Sequential 32-bit divider for the MULDIV unit. It is the division counterpart of the combinational multiplier and shares that block's operand/mode conventions: a mode bit selects unsigned or signed arithmetic. It computes one quotient bit per clock by restoring division and returns quotient and remainder with a one-cycle completion strobe. It sits beside the multiplier in the MULDIV wrapper, which selects between their results.

## Interface
- DIVW, 32, operand/result width; only 32 is supported in this revision.
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- DIVST  input  1  start request; sampled on CLK while idle.
- DIVSM  input  1  mode: 0 = unsigned, 1 = signed (two's complement); sampled with DIVST.
- DIVA  input  32  dividend; sampled with DIVST.
- DIVB  input  32  divisor; sampled with DIVST.
- DIVQ  output  32  quotient; holds the last result.
- DIVR  output  32  remainder; holds the last result.
- DIVBUSY  output  1  high while a division is in progress.
- DIVEND  output  1  one-cycle completion pulse.
- DIVZ  output  1  divisor was zero on the last completed division; holds until the next completion.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, DIVST=1: latch the mode, the magnitudes |DIVA| and |DIVB| (raw values when DIVSM=0), both operand signs, and the divisor-zero flag. Set the bit counter to 31 and go to CALC.
- IDLE, DIVST=0: stay in IDLE.
- CALC, one bit per cycle:
  - Shift the {partial remainder, dividend} pair left by one.
  - Trial-subtract the divisor using a 33-bit difference.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - When the counter reaches 0, go to FIX.
- FIX:
  - Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Division truncates toward zero.
  - Write DIVQ, DIVR and DIVZ, pulse DIVEND, and return to IDLE.
- Divisor zero, either mode: DIVQ=0xFFFFFFFF, DIVR=DIVA (raw), DIVZ=1. Latency is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: DIVQ=0x80000000, DIVR=0. This is a wrap, not an error, and DIVZ=0.
- DIVST is ignored in CALC and FIX. Operand changes after the sampling edge have no effect.
- DIVQ, DIVR and DIVZ change only in FIX, so they stay stable throughout a computation.

## Timing
- Reset values: state IDLE; DIVQ=0, DIVR=0, DIVBUSY=0, DIVEND=0, DIVZ=0; all working registers 0.
- Edge 0 samples DIVST=1. DIVBUSY is high after edges 0 through 32; calc iterations occur on edges 1–32.
- Edge 33 (FIX → IDLE) updates the results, drops DIVBUSY and raises DIVEND for exactly one cycle.
- Fixed latency is 33 clocks from the start edge to valid results. DIVEND and the new DIVQ/DIVR are visible together.
- DIVST high during the DIVEND cycle (state IDLE) is accepted, giving back-to-back operation with no gap.
- RST asserted mid-operation aborts immediately: outputs return to their reset values and no DIVEND is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package qlk0rmuldiv_pkg holds:
  - the DIVW constant;
  - the state enum (IDLE/CALC/FIX);
  - the DIVZ result constants (quotient all-ones);
  - the counter width (5 bits).
- Sub-module qlk0rmuldiv1v1_div_step: combinational single iteration. It takes the partial remainder, the next dividend bit and the divisor, and returns the new remainder and the quotient bit. The top level holds the FSM, counter, sign handling and output registers.

## Test plan
- Unsigned 100/7 (DIVSM=0): DIVQ=14, DIVR=2, DIVZ=0. DIVEND is high only in the cycle after edge 33, and DIVBUSY is high after edges 0–32.
- Signed −100/7 (DIVA=0xFFFFFF9C, DIVSM=1): DIVQ=0xFFFFFFF2, DIVR=0xFFFFFFFE.
- Signed 100/−7: DIVQ=0xFFFFFFF2, DIVR=2.
- Signed 0x80000000/0xFFFFFFFF: DIVQ=0x80000000, DIVR=0, DIVZ=0.
- Zero divisor:
  - 0x1234/0 → DIVQ=0xFFFFFFFF, DIVR=0x1234, DIVZ=1.
  - A following 9/3 → DIVQ=3, DIVR=0, DIVZ=0.
- Handshake:
  - DIVST pulsed on edge 10 of a busy operation is ignored, and the result is unchanged.
  - DIVST held high in the DIVEND cycle starts the next division, whose DIVEND comes 33 edges later.
- Reset: assert RST at edge 15 of a division → all outputs 0 immediately. After release, no DIVEND appears and a new 50/5 gives DIVQ=10, DIVR=0.
